// File: rtl/my_ram_pkg.sv
// my_ram_pkg
//   Shared types and default sizing for the parametrised RAM bank.
//   - my_ram_state_t   : clear-sequencer state (IDLE / CLEAR)
//   - MY_RAM_WIDTH_DEF : default data word width
//   - MY_RAM_DEPTH_DEF : default number of words
package my_ram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } my_ram_state_t;

   localparam int MY_RAM_WIDTH_DEF = 16;
   localparam int MY_RAM_DEPTH_DEF = 512;

endpackage : my_ram_pkg

// File: rtl/my_ram_if.sv
// my_ram_if
//   User-side bus of the RAM bank.
//   Parameters: WIDTH (data bits), DEPTH (words); ADDR_W is derived.
//   Signals:
//     in    - write data             (master -> slave)
//     addr  - read/write address     (master -> slave)
//     load  - write enable           (master -> slave)
//     clr   - full-array clear req   (master -> slave)
//     out   - read data, comb.       (slave -> master)
//     ready - array valid            (slave -> master)
//   Handshake: a write is accepted on a posedge where ready=1, load=1,
//   clr=0 and addr < DEPTH. While ready=0 load is ignored and out reads 0.
//   clr needs no handshake: it is acted on at any posedge it is high.
interface my_ram_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 512
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]  in;
   logic [ADDR_W-1:0] addr;
   logic              load;
   logic              clr;
   logic [WIDTH-1:0]  out;
   logic              ready;

   modport master (
      output in, addr, load, clr,
      input  out, ready
   );

   modport slave (
      input  in, addr, load, clr,
      output out, ready
   );

endinterface : my_ram_if

// File: rtl/my_ram_clr_seq.sv
// my_ram_clr_seq
//   Clear sequencer: sweeps ptr over 0..DEPTH-1 writing zeros after
//   reset or on a clr request, then parks in IDLE.
//   Ports:
//     clk, rst_n  - clock, synchronous active-low reset
//     clr         - restart the sweep from 0
//     ready       - state == IDLE
//     clr_we      - zero-write strobe for the array this cycle
//     clr_addr    - address of the zero-write
//     state       - current state (debug visibility)
module my_ram_clr_seq
   import my_ram_pkg::*;
#(
   parameter  int DEPTH  = MY_RAM_DEPTH_DEF,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   output logic              ready,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output my_ram_state_t     state
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clr) begin
                  state <= CLEAR;
                  ptr   <= '0;
               end
            end
            CLEAR: begin
               if (clr) begin
                  ptr <= '0;
               end else if (ptr == LAST) begin
                  state <= IDLE;
               end else begin
                  ptr <= ptr + ADDR_W'(1);
               end
            end
            default: begin
               state <= CLEAR;
               ptr   <= '0;
            end
         endcase
      end
   end

   assign ready    = (state == IDLE);
   // Reset and restart edges do not write: the sweep writes only on
   // edges where it actually advances.
   assign clr_we   = (state == CLEAR) && rst_n && !clr;
   assign clr_addr = ptr;

endmodule : my_ram_clr_seq

// File: rtl/my_ram_param.sv
// my_ram_param
//   Parametrised synchronous-write RAM with built-in clear sequencer.
//   Drop-in for the fixed RAMs when WIDTH=16.
//   Parameters: WIDTH (>=1), DEPTH (>=2, any value).
//   Ports:
//     clk, rst_n - clock, synchronous active-low reset
//     bus        - my_ram_if slave (in, addr, load, clr, out, ready)
//     state      - clear-sequencer state (debug visibility)
//   Build option: MY_RAM_BYPASS_EN selects write-first reads; without it
//   out shows the old word until the write commits on the posedge.
module my_ram_param
   import my_ram_pkg::*;
#(
   parameter int WIDTH = MY_RAM_WIDTH_DEF,
   parameter int DEPTH = MY_RAM_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   my_ram_if.slave       bus,
   output my_ram_state_t state
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]  mem [DEPTH];

   logic              ready;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              in_range;
   logic              user_hit;
   logic              user_we;
   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [WIDTH-1:0]  wd;
   logic [WIDTH-1:0]  rd;

   my_ram_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.clr),
      .ready    (ready),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .state    (state)
   );

   // Only matters when DEPTH is not a power of two.
   assign in_range = (32'(bus.addr) < 32'(DEPTH));

   // A user write: IDLE, clr has priority over load, address in range.
   assign user_hit = ready && bus.load && !bus.clr && in_range;
   assign user_we  = user_hit && rst_n;

   // Sequencer and user writes are mutually exclusive (CLEAR vs IDLE).
   assign we = clr_we || user_we;
   assign wa = clr_we ? clr_addr : bus.addr;
   assign wd = clr_we ? '0 : bus.in;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= wd;
      end
   end

   always_comb begin
      rd = '0;
      if (ready && in_range) begin
         rd = mem[bus.addr];
      end
`ifdef MY_RAM_BYPASS_EN
      if (user_hit) begin
         rd = bus.in;
      end
`endif
   end

   assign bus.out   = rd;
   assign bus.ready = ready;

endmodule : my_ram_param

// File: tb/tb_my_ram_param.sv
// tb_my_ram_param
//   Directed bench for my_ram_param with two instances: DEPTH=8 (main
//   behaviour) and DEPTH=6 (out-of-range addresses). Inputs change 1ns
//   after each posedge; expected values are queued at that time and
//   compared at the following negedge.
module tb_my_ram_param;
   import my_ram_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   my_ram_if #(.WIDTH(16), .DEPTH(8)) bus8 ();
   my_ram_if #(.WIDTH(16), .DEPTH(6)) bus6 ();
   my_ram_state_t state8;
   my_ram_state_t state6;

   my_ram_param #(.WIDTH(16), .DEPTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave),
      .state (state8)
   );

   my_ram_param #(.WIDTH(16), .DEPTH(6)) dut6 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus6.slave),
      .state (state6)
   );

`ifdef MY_RAM_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   localparam int S_OUT8 = 0, S_RDY8 = 1, S_ST8 = 2, S_OUT6 = 3, S_RDY6 = 4;

   logic [15:0] exp_q [$];
   int          sel_q [$];
   string       nm_q  [$];
   int          checks = 0;
   int          errors = 0;

   // ---------------- scoreboard monitor ----------------
   logic [15:0] m_exp, m_act;
   int          m_sel;
   string       m_nm;

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         m_exp = exp_q.pop_front();
         m_sel = sel_q.pop_front();
         m_nm  = nm_q.pop_front();
         case (m_sel)
            S_OUT8:  m_act = bus8.out;
            S_RDY8:  m_act = {15'd0, bus8.ready};
            S_ST8:   m_act = {15'd0, state8};
            S_OUT6:  m_act = bus6.out;
            default: m_act = {15'd0, bus6.ready};
         endcase
         checks++;
         if (m_act !== m_exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", m_nm, m_act, m_exp);
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_sig(input int sel, input logic [15:0] v, input string nm);
      sel_q.push_back(sel);
      exp_q.push_back(v);
      nm_q.push_back(nm);
   endtask

   task automatic drive8(input logic ld, input logic cl, input logic [2:0] a, input logic [15:0] d);
      bus8.load = ld;
      bus8.clr  = cl;
      bus8.addr = a;
      bus8.in   = d;
   endtask

   task automatic write8(input logic [2:0] a, input logic [15:0] d);
      tick();
      drive8(1'b1, 1'b0, a, d);
      tick();
      drive8(1'b0, 1'b0, a, 16'h0000);
      expect_sig(S_OUT8, d, "write8_readback");
   endtask

   task automatic read8(input logic [2:0] a, input logic [15:0] v);
      tick();
      drive8(1'b0, 1'b0, a, 16'h0000);
      expect_sig(S_OUT8, v, "read8");
   endtask

   task automatic write6(input logic [2:0] a, input logic [15:0] d);
      tick();
      bus6.load = 1'b1; bus6.addr = a; bus6.in = d;
      tick();
      bus6.load = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      drive8(1'b1, 1'b0, 3'd3, 16'hAAAA);
      bus6.load = 1'b0; bus6.clr = 1'b0; bus6.addr = 3'd0; bus6.in = 16'h0000;

      // Reset held low: block sits in CLEAR, out and ready low.
      repeat (2) begin
         tick();
         expect_sig(S_RDY8, 16'd0, "reset_ready");
         expect_sig(S_OUT8, 16'd0, "reset_out");
         expect_sig(S_ST8, 16'(CLEAR), "reset_state");
      end
      tick();
      rst_n = 1'b1;

      // DEPTH=8 ready after 8 high edges, DEPTH=6 after 6.
      for (int i = 1; i <= 8; i++) begin
         tick();
         expect_sig(S_RDY8, (i == 8) ? 16'd1 : 16'd0, "release_ready8");
         expect_sig(S_RDY6, (i >= 6) ? 16'd1 : 16'd0, "release_ready6");
         if (i < 8)
            expect_sig(S_OUT8, 16'd0, "clear_out");
         else
            expect_sig(S_OUT8, BYPASS ? 16'hAAAA : 16'h0000, "first_ready_out");
      end
      tick();
      expect_sig(S_OUT8, 16'hAAAA, "post_ready_write");
      expect_sig(S_ST8, 16'(IDLE), "idle_state");

      // Write/read.
      write8(3'd5, 16'h1234);
      write8(3'd0, 16'hBEEF);
      read8(3'd5, 16'h1234);
      read8(3'd0, 16'hBEEF);
      read8(3'd7, 16'h0000);
      read8(3'd3, 16'hAAAA);

      // clr in IDLE with a competing load.
      tick();
      drive8(1'b1, 1'b1, 3'd5, 16'hFFFF);
      expect_sig(S_RDY8, 16'd1, "clr_pre_ready");
      tick();
      drive8(1'b0, 1'b0, 3'd5, 16'h0000);
      expect_sig(S_RDY8, 16'd0, "clr_ready_fall");
      for (int i = 1; i <= 8; i++) begin
         tick();
         expect_sig(S_RDY8, (i == 8) ? 16'd1 : 16'd0, "clr_sweep_ready");
      end
      expect_sig(S_OUT8, 16'h0000, "clr_addr5_zero");
      read8(3'd0, 16'h0000);

      // clr re-pulsed 3 cycles into a sweep.
      tick();
      drive8(1'b0, 1'b1, 3'd0, 16'h0000);
      tick();
      drive8(1'b0, 1'b0, 3'd0, 16'h0000);
      expect_sig(S_RDY8, 16'd0, "repulse_fall");
      repeat (3) tick();
      drive8(1'b0, 1'b1, 3'd0, 16'h0000);
      tick();
      drive8(1'b0, 1'b0, 3'd0, 16'h0000);
      for (int i = 1; i <= 8; i++) begin
         tick();
         expect_sig(S_RDY8, (i == 8) ? 16'd1 : 16'd0, "repulse_ready");
      end

      // Same-cycle read of a write.
      write8(3'd2, 16'h1111);
      tick();
      drive8(1'b1, 1'b0, 3'd2, 16'h2222);
      expect_sig(S_OUT8, BYPASS ? 16'h2222 : 16'h1111, "same_cycle_pre");
      tick();
      drive8(1'b0, 1'b0, 3'd2, 16'h0000);
      expect_sig(S_OUT8, 16'h2222, "same_cycle_post");

      // DEPTH=6: fill, then write out of range.
      for (int i = 0; i < 6; i++) write6(3'(i), 16'h0100 + 16'(i));
      tick();
      bus6.load = 1'b1; bus6.addr = 3'd7; bus6.in = 16'h5555;
      expect_sig(S_OUT6, 16'h0000, "oor_out_same");
      tick();
      bus6.load = 1'b0;
      expect_sig(S_OUT6, 16'h0000, "oor_out_after");
      tick();
      bus6.addr = 3'd6;
      expect_sig(S_OUT6, 16'h0000, "oor_addr6");
      for (int i = 0; i < 6; i++) begin
         tick();
         bus6.addr = 3'(i);
         expect_sig(S_OUT6, 16'h0100 + 16'(i), "oor_untouched");
      end

      // Drain the scoreboard with a bound.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule : tb_my_ram_param
